// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: sequences rs1/rs2 register file reads, immediate substitution and writeback bypass for one instruction
module operand_fetch_ctrl #(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            rf_ren,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic            out_illegal
);
  typedef enum logic [2:0] {IDLE, RD1, RD2, CAP1, CAP2, OUT} state_t;
  state_t state, state_nx;
  logic two_rd, one_rd, no_rd, ill;
  logic two_q;
  logic [4:0] rs1_q, rs2_q;
  logic [XLEN-1:0] imm_q;
  logic pend_v;
  logic [XLEN-1:0] pend_d;
  logic [4:0] cap_idx;
  logic [XLEN-1:0] cap_val;
  logic issue_hit;
  assign two_rd = in_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign one_rd = in_opcode inside {7'b0010011, 7'b0000011, 7'b1100111};
  assign no_rd  = in_opcode inside {7'b0110111, 7'b0010111, 7'b1101111};
  assign ill    = !(two_rd || one_rd || no_rd);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !in_valid ? IDLE : (two_rd || one_rd) ? RD1 : OUT;
      RD1:     state_nx = two_q ? RD2 : CAP1;
      RD2:     state_nx = CAP2;
      CAP1:    state_nx = OUT;
      CAP2:    state_nx = OUT;
      OUT:     state_nx = out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == OUT;
    rf_ren    = state == RD1 || state == RD2;
    rf_raddr  = state == RD1 ? rs1_q : state == RD2 ? rs2_q : 5'd0;
  end
  // The register file returns pre-write data, so a write in the issue cycle must be remembered.
  assign issue_hit = BYPASS_EN && rf_ren && wb_en && wb_addr == rf_raddr && rf_raddr != 5'd0;
  assign cap_idx   = state == CAP2 ? rs2_q : rs1_q;
  assign cap_val   = cap_idx == 5'd0 ? '0 :
                     (BYPASS_EN && wb_en && wb_addr == cap_idx) ? wb_data :
                     pend_v ? pend_d : rf_rdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      two_q       <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pend_v      <= 1'b0;
      pend_d      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        two_q       <= two_rd;
        rs1_q       <= in_rs1;
        rs2_q       <= in_rs2;
        imm_q       <= in_imm;
        out_illegal <= ill;
        out_op1     <= '0;
        out_op2     <= no_rd ? in_imm : '0;
      end
      if (rf_ren) begin
        pend_v <= issue_hit;
        pend_d <= wb_data;
      end
      if (state == RD2 || state == CAP1) out_op1 <= cap_val;
      if (state == CAP1) out_op2 <= imm_q;
      if (state == CAP2) out_op2 <= cap_val;
    end
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// tb_operand_fetch_ctrl: table vectors, corner sequences and random transactions against a register-snapshot model
module tb_operand_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, wb_en;
  logic [6:0] in_opcode;
  logic [4:0] in_rs1, in_rs2, wb_addr;
  logic [31:0] in_imm, rf_rdata, wb_data;
  logic b_in_ready, b_rf_ren, b_out_valid, b_ill;
  logic n_in_ready, n_rf_ren, n_out_valid, n_ill;
  logic [4:0] b_rf_raddr, n_rf_raddr;
  logic [31:0] b_op1, b_op2, n_op1, n_op2;
  logic [31:0] regs [32];
  logic sw_en [16];
  logic [4:0] sw_addr [16];
  logic [31:0] sw_data [16];
  int checks = 0, errors = 0;
  typedef struct {
    logic [6:0] op; logic [4:0] a; logic [4:0] b; logic [31:0] imm;
    logic [31:0] e1; logic [31:0] e2; logic ill; int lat;
  } vec_t;
  vec_t tbl [10];
  logic [6:0] op_list [13];

  always #5 clk = ~clk;

  operand_fetch_ctrl #(.XLEN(32), .BYPASS_EN(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .rf_ren(b_rf_ren), .rf_raddr(b_rf_raddr),
    .rf_rdata(rf_rdata), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_op1(b_op1), .out_op2(b_op2), .out_illegal(b_ill));

  operand_fetch_ctrl #(.XLEN(32), .BYPASS_EN(1'b0)) u_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .rf_ren(n_rf_ren), .rf_raddr(n_rf_raddr),
    .rf_rdata(rf_rdata), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_op1(n_op1), .out_op2(n_op2), .out_illegal(n_ill));

  // Register file: synchronous read returning pre-write data.
  always @(posedge clk) begin
    if (b_rf_ren) rf_rdata <= regs[b_rf_raddr];
    if (wb_en) regs[wb_addr] <= wb_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void classify(input logic [6:0] op, output int nrd, output bit ill);
    ill = 1'b0;
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: nrd = 2;
      7'b0010011, 7'b0000011, 7'b1100111: nrd = 1;
      7'b0110111, 7'b0010111, 7'b1101111: nrd = 0;
      default: begin nrd = 0; ill = 1'b1; end
    endcase
  endfunction

  task automatic drive_wb(input int mode, input int c, input logic [4:0] a, input logic [4:0] b);
    int p;
    if (mode == 1) begin
      p = $urandom % 3;
      wb_en = 1'($urandom % 2);
      wb_addr = p == 0 ? a : p == 1 ? b : 5'($urandom);
      wb_data = $urandom;
    end else begin
      wb_en   = c < 16 ? sw_en[c] : 1'b0;
      wb_addr = c < 16 ? sw_addr[c] : 5'd0;
      wb_data = c < 16 ? sw_data[c] : 32'd0;
    end
  endtask

  task automatic clr_sched();
    for (int i = 0; i < 16; i++) begin sw_en[i] = 1'b0; sw_addr[i] = '0; sw_data[i] = '0; end
  endtask

  task automatic garbage_in();
    in_valid = 1'($urandom % 2); in_opcode = 7'($urandom); in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom); in_imm = $urandom;
  endtask

  // One instruction from accept to handshake; caller is at a negedge with the DUT idle.
  task automatic txn(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b, input logic [31:0] imm,
                     input int hold, input int mode, output logic [31:0] o1b, output logic [31:0] o2b,
                     output logic [31:0] o1n, output logic [31:0] o2n, output logic oill, output int mlat);
    int nrd, lat;
    bit ill;
    logic [31:0] s1 [5];
    logic [31:0] s2 [5];
    logic [31:0] e1b, e2b, e1n, e2n;
    classify(op, nrd, ill);
    lat = nrd == 2 ? 4 : nrd == 1 ? 3 : 1;
    mlat = -1;
    for (int i = 0; i < 5; i++) begin s1[i] = '0; s2[i] = '0; end
    chk("accept_in_ready", {31'd0, b_in_ready}, 32'd1);
    chk("accept_rf_ren", {31'd0, b_rf_ren}, 32'd0);
    in_valid = 1'b1; in_opcode = op; in_rs1 = a; in_rs2 = b; in_imm = imm; out_ready = 1'b0;
    s1[0] = regs[a]; s2[0] = regs[b];
    drive_wb(mode, 0, a, b);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      s1[c] = regs[a]; s2[c] = regs[b];
      if (b_out_valid && mlat < 0) mlat = c;
      chk("rf_ren", {31'd0, b_rf_ren}, {31'd0, (c == 1 && nrd > 0) || (c == 2 && nrd == 2)});
      chk("rf_raddr", {27'd0, b_rf_raddr}, {27'd0, (c == 1 && nrd > 0) ? a : (c == 2 && nrd == 2) ? b : 5'd0});
      chk("out_valid_lat", {31'd0, b_out_valid}, {31'd0, c == lat});
      chk("in_ready_busy", {31'd0, b_in_ready}, 32'd0);
      garbage_in();
      drive_wb(mode, c, a, b);
    end
    e1b = '0; e2b = '0; e1n = '0; e2n = '0;
    if (!ill) begin
      e2b = imm; e2n = imm;
      if (nrd > 0) begin
        e1b = a == 0 ? '0 : s1[3];
        e1n = a == 0 ? '0 : s1[1];
      end
      if (nrd == 2) begin
        e2b = b == 0 ? '0 : s2[4];
        e2n = b == 0 ? '0 : s2[2];
      end
    end
    o1b = b_op1; o2b = b_op2; o1n = n_op1; o2n = n_op2; oill = b_ill;
    chk("op1_byp", b_op1, e1b);
    chk("op2_byp", b_op2, e2b);
    chk("op1_nobyp", n_op1, e1n);
    chk("op2_nobyp", n_op2, e2n);
    chk("illegal", {31'd0, b_ill}, {31'd0, ill});
    chk("illegal_nobyp", {31'd0, n_ill}, {31'd0, ill});
    chk("out_valid_nobyp", {31'd0, n_out_valid}, 32'd1);
    out_ready = hold == 0;
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, b_out_valid}, 32'd1);
      chk("hold_op1", b_op1, e1b);
      chk("hold_op2", b_op2, e2b);
      chk("hold_in_ready", {31'd0, b_in_ready}, 32'd0);
      chk("hold_rf_ren", {31'd0, b_rf_ren}, 32'd0);
      garbage_in();
      drive_wb(mode, lat + h, a, b);
      out_ready = h == hold;
    end
    @(negedge clk);
    chk("post_valid", {31'd0, b_out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, b_in_ready}, 32'd1);
    chk("post_in_ready_nobyp", {31'd0, n_in_ready}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
  endtask

  logic [31:0] r1b, r2b, r1n, r2n;
  logic rill;
  int rlat;

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    clr_sched();
    op_list = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011, 7'b1100111,
                7'b0110111, 7'b0010111, 7'b1101111, 7'h7F, 7'h00, 7'h5B, 7'h0F};
    tbl[0] = '{7'b0110111, 5'd9, 5'd9, 32'h12345000, 32'h0, 32'h12345000, 1'b0, 1};
    tbl[1] = '{7'b0110011, 5'd5, 5'd6, 32'h0, 32'hAAAA0001, 32'h7, 1'b0, 4};
    tbl[2] = '{7'b0010011, 5'd0, 5'd9, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 1'b0, 3};
    tbl[3] = '{7'h7F, 5'd5, 5'd6, 32'h55, 32'h0, 32'h0, 1'b1, 1};
    tbl[4] = '{7'b0100011, 5'd6, 5'd5, 32'h0, 32'h7, 32'hAAAA0001, 1'b0, 4};
    tbl[5] = '{7'b0000011, 5'd9, 5'd1, 32'h10, 32'h99, 32'h10, 1'b0, 3};
    tbl[6] = '{7'b1101111, 5'd5, 5'd6, 32'h800, 32'h0, 32'h800, 1'b0, 1};
    tbl[7] = '{7'b1100011, 5'd5, 5'd0, 32'h0, 32'hAAAA0001, 32'h0, 1'b0, 4};
    tbl[8] = '{7'b1100111, 5'd6, 5'd2, 32'h4, 32'h7, 32'h4, 1'b0, 3};
    tbl[9] = '{7'b0010111, 5'd5, 5'd6, 32'hFFFFF000, 32'h0, 32'hFFFFF000, 1'b0, 1};
    #2;
    chk("rst_in_ready", {31'd0, b_in_ready}, 32'd1);
    chk("rst_rf_ren", {31'd0, b_rf_ren}, 32'd0);
    chk("rst_rf_raddr", {27'd0, b_rf_raddr}, 32'd0);
    chk("rst_out_valid", {31'd0, b_out_valid}, 32'd0);
    chk("rst_op1", b_op1, 32'd0);
    chk("rst_op2", b_op2, 32'd0);
    chk("rst_illegal", {31'd0, b_ill}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wb_en = 1'b1; wb_addr = 5'(i);
      wb_data = i == 0 ? 32'hFFFFFFFF : (i == 3 || i == 4) ? 32'h1 : i == 5 ? 32'hAAAA0001 :
                i == 6 ? 32'h7 : i == 9 ? 32'h99 : (32'h0C0D0000 | i);
      @(negedge clk);
    end
    wb_en = 1'b0;
    @(negedge clk);

    // Reset in the middle of RD2 abandons the fetch.
    in_valid = 1'b1; in_opcode = 7'b0110011; in_rs1 = 5'd5; in_rs2 = 5'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rd2_rf_ren", {31'd0, b_rf_ren}, 32'd1);
    chk("rd2_rf_raddr", {27'd0, b_rf_raddr}, 32'd6);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_rf_ren", {31'd0, b_rf_ren}, 32'd0);
    chk("async_rst_in_ready", {31'd0, b_in_ready}, 32'd1);
    @(negedge clk);
    chk("rst_mid_rf_raddr", {27'd0, b_rf_raddr}, 32'd0);
    chk("rst_mid_valid", {31'd0, b_out_valid}, 32'd0);
    chk("rst_mid_op1", b_op1, 32'd0);
    chk("rst_mid_op2", b_op2, 32'd0);
    chk("rst_mid_illegal", {31'd0, b_ill}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("after_rst_valid", {31'd0, b_out_valid}, 32'd0);
      chk("after_rst_ready", {31'd0, b_in_ready}, 32'd1);
    end

    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, i % 3, 0, r1b, r2b, r1n, r2n, rill, rlat);
      chk("tbl_op1", r1b, tbl[i].e1);
      chk("tbl_op2", r2b, tbl[i].e2);
      chk("tbl_illegal", {31'd0, rill}, {31'd0, tbl[i].ill});
      chk("tbl_latency", rlat, tbl[i].lat);
    end

    // Bypass: pending path for rs1 (write in RD1), capture path for rs2 (write in CAP2).
    clr_sched();
    sw_en[1] = 1'b1; sw_addr[1] = 5'd3; sw_data[1] = 32'hDEAD;
    sw_en[3] = 1'b1; sw_addr[3] = 5'd4; sw_data[3] = 32'hBEEF;
    txn(7'b0110011, 5'd3, 5'd4, 32'h0, 0, 0, r1b, r2b, r1n, r2n, rill, rlat);
    chk("byp_pending_op1", r1b, 32'hDEAD);
    chk("byp_capture_op2", r2b, 32'hBEEF);
    chk("nobyp_op1", r1n, 32'h1);
    chk("nobyp_op2", r2n, 32'h1);

    // Backpressure with writebacks to rs1 during OUT.
    clr_sched();
    for (int c = 4; c < 12; c++) begin sw_en[c] = 1'b1; sw_addr[c] = 5'd5; sw_data[c] = 32'h5555 + c; end
    txn(7'b0110011, 5'd5, 5'd6, 32'h0, 6, 0, r1b, r2b, r1n, r2n, rill, rlat);
    chk("bp_op1", r1b, 32'hAAAA0001);
    chk("bp_op2", r2b, 32'h7);
    clr_sched();

    for (int i = 0; i < 40; i++) begin
      logic [4:0] a, b;
      a = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      b = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      txn(op_list[$urandom % 13], a, b, $urandom, $urandom % 4, 1, r1b, r2b, r1n, r2n, rill, rlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
- Sequences operand fetch for one decoded instruction through the core's single-read-port register file.
- Classifies the opcode, issues one or two synchronous reads, and captures the results into the rs1 and rs2 operand registers.
- Substitutes the immediate for op2 where the instruction needs it, bypasses same-cycle writebacks, and hands the operand pair downstream with a valid/ready handshake.
- Sits between the decoder and the ALU/AGU stage.

Parameters:
- XLEN, 32, operand and data width.
- BYPASS_EN, 1, when 1 writeback data is forwarded into captured operands; when 0 register file data is used unmodified.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  decoded instruction valid
- in_ready  output  1  block can accept an instruction
- in_opcode  input  7  instruction opcode [6:0]
- in_rs1  input  5  rs1 index
- in_rs2  input  5  rs2 index
- in_imm  input  XLEN  sign-extended immediate
- rf_ren  output  1  register file read enable
- rf_raddr  output  5  register file read address
- rf_rdata  input  XLEN  read data, valid the cycle after rf_ren
- wb_en  input  1  register file write this cycle
- wb_addr  input  5  write address
- wb_data  input  XLEN  write data
- out_valid  output  1  operands valid
- out_ready  input  1  downstream accepts
- out_op1  output  XLEN  operand 1
- out_op2  output  XLEN  operand 2 (rs2 value or immediate)
- out_illegal  output  1  opcode not recognised

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - in_ready=1, rf_ren=0, rf_raddr=0.
  - out_valid=0, out_op1=0, out_op2=0, out_illegal=0.
  - An in-flight fetch is abandoned with no output.
- Opcode classes:
  - Needs rs1 and rs2: R (0110011), store (0100011), branch (1100011).
  - Needs rs1 only, op2=imm: I-ALU (0010011), load (0000011), jalr (1100111).
  - Needs no reads, op1=0, op2=imm: lui (0110111), auipc (0010111), jal (1101111).
  - Any other opcode is illegal: op1=op2=0, out_illegal=1.
- States: IDLE, RD1, RD2, CAP1, CAP2, OUT.
  - IDLE: in_ready=1 in this state only. On in_valid, latch opcode, indices and imm.
    - Two-read class goes to RD1.
    - One-read class goes to RD1.
    - No-read or illegal class goes to OUT.
  - RD1: rf_ren=1, rf_raddr=rs1. Next state is RD2 for the two-read class, CAP1 otherwise.
  - RD2: capture rs1 from rf_rdata; rf_ren=1, rf_raddr=rs2. Next state CAP2.
  - CAP1: capture rs1; op2=imm. Next state OUT.
  - CAP2: capture rs2 into op2. Next state OUT.
  - OUT: out_valid=1; operands and out_illegal are held stable. On out_ready, go to IDLE.
- rf_ren=0 and rf_raddr=0 in every state except RD1 and RD2.
- Latency, with the accept handshake in cycle T:
  - Two reads: out_valid first high in T+4.
  - One read: out_valid first high in T+3.
  - No read or illegal: out_valid first high in T+1.
  - Next accept is no earlier than the cycle after the output handshake.
- x0: index 0 is still read, but the captured value is forced to 0 regardless of rf_rdata or bypass.
- Bypass (BYPASS_EN=1):
  - The register file returns pre-write data when a read and a write to the same address occur in the same cycle.
  - Issue cycle: if wb_en && wb_addr==index && index!=0, latch wb_data as pending data.
  - Capture cycle: priority is a matching wb_data in the capture cycle, then pending data, then rf_rdata.
  - Writebacks during OUT do not alter the held operands.
- in_valid while not in IDLE is ignored; upstream holds it.
- The upstream in_* inputs are not sampled after the accept cycle.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. Reset and no-read instruction: reset asserted mid-RD2 → next cycle all outputs are 0 and in_ready=1. Then send lui with imm=0x12345000 → out_valid at T+1, op1=0, op2=0x12345000, out_illegal=0, no rf_ren pulse.
2. R-type with two reads: rs1=5 (holds 0xAAAA0001), rs2=6 (holds 0x00000007) → rf_raddr=5 at T+1, rf_raddr=6 at T+2, out_valid at T+4 with op1=0xAAAA0001, op2=0x7.
3. I-type with x0: addi with rs1=0, rf_rdata forced to 0xFFFFFFFF, imm=0xFFFFFFFC → op1=0, op2=0xFFFFFFFC, out_valid at T+3.
4. Bypass: R-type rs1=3, rs2=4.
   - wb_en with addr 3, data 0xDEAD in RD1 (pending path).
   - wb_en with addr 4, data 0xBEEF in CAP2 (capture path).
   - Register file returns stale 0x1 for both → op1=0xDEAD, op2=0xBEEF.
   - Repeat with BYPASS_EN=0 → op1=op2=0x1.
5. Backpressure: hold out_ready=0 for 6 cycles in OUT while wb_en writes rs1 and in_valid toggles → operands unchanged, in_ready=0 throughout, single transfer when out_ready=1, in_ready=1 the following cycle.
6. Illegal opcode 0x7F: out_valid at T+1, out_illegal=1, op1=op2=0, rf_ren never asserted; next legal instruction clears out_illegal.
